// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multicycle control FSM for the 8-bit TinyMIPS datapath
// Optional feature macro: ADDI_EN (adds the ADDIEX/ADDIWR states for addi).
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
`ifdef ADDI_EN
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
`else
        JEX     = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t cur, nxt;
    // run stays low while reset is low and for the partial cycle after release,
    // so the first full cycle after release is a clean FETCH1.
    logic   run;
    logic   pcwrite, branch;

    // State register; reset parks the FSM in FETCH1 with outputs suppressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= FETCH1;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            cur <= run ? nxt : FETCH1;
        end
    end

    // Next-state and Moore output decode; pcen and RTYPEEX alucontrol are the only input-dependent outputs.
    always_comb begin
        nxt        = FETCH1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        pcsource   = 2'b00;
        alucontrol = 3'b000;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        if (run) begin
            case (cur)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    memread    = 1'b1;
                    irwrite    = 4'b0001 << cur[1:0];
                    alusrcb    = 2'b01;
                    alucontrol = 3'b010;
                    pcwrite    = 1'b1;
                    case (cur)
                        FETCH1:  nxt = FETCH2;
                        FETCH2:  nxt = FETCH3;
                        FETCH3:  nxt = FETCH4;
                        default: nxt = DECODE;
                    endcase
                end
                DECODE: begin
                    alusrcb    = 2'b11;
                    alucontrol = 3'b010;
                    case (op)
                        OP_LB, OP_SB: nxt = MEMADR;
                        OP_RTYP:      nxt = RTYPEEX;
                        OP_BEQ:       nxt = BEQEX;
                        OP_J:         nxt = JEX;
`ifdef ADDI_EN
                        OP_ADDI:      nxt = ADDIEX;
`endif
                        default:      nxt = FETCH1;
                    endcase
                end
                MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = 3'b010;
                    nxt        = (op == OP_LB) ? LBRD : SBWR;
                end
                LBRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    nxt     = LBWR;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                    nxt = RTYPEWR;
                end
                RTYPEWR: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX: begin
                    alusrca    = 1'b1;
                    alucontrol = 3'b110;
                    branch     = 1'b1;
                    pcsource   = 2'b01;
                end
                JEX: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
`ifdef ADDI_EN
                ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = 3'b010;
                    nxt        = ADDIWR;
                end
                ADDIWR: begin
                    regwrite = 1'b1;
                end
`endif
                default: nxt = FETCH1;
            endcase
        end
        pcen  = pcwrite | (branch & zero);
        state = cur;
    end

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - scoreboard bench for mips_controller
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] irwrite, state;
    logic [2:0] alucontrol;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic [3:0] irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       pcen;
        logic [1:0] pcsource;
        logic [2:0] alucontrol;
        logic [3:0] state;
    } out_t;

    out_t exp_q[$];
    out_t e, g;
    int   errors = 0;
    int   checks = 0;

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .pcen(pcen), .pcsource(pcsource),
        .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic out_t model_out(input int st, input logic [5:0] f, input logic z);
        out_t       o;
        logic [3:0] one;
        o       = '0;
        one     = 4'b0001;
        o.state = st[3:0];
        case (st)
            0, 1, 2, 3: begin
                o.memread = 1; o.irwrite = one << st[1:0]; o.alusrcb = 2'b01;
                o.alucontrol = 3'b010; o.pcen = 1;
            end
            4:  begin o.alusrcb = 2'b11; o.alucontrol = 3'b010; end
            5:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
            6:  begin o.memread = 1; o.iord = 1; end
            7:  begin o.regwrite = 1; o.memtoreg = 1; end
            8:  begin o.memwrite = 1; o.iord = 1; end
            9:  begin o.alusrca = 1; o.alucontrol = rtype_alu(f); end
            10: begin o.regwrite = 1; o.regdst = 1; end
            11: begin o.alusrca = 1; o.alucontrol = 3'b110; o.pcsource = 2'b01; o.pcen = z; end
            12: begin o.pcen = 1; o.pcsource = 2'b10; end
            13: begin o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
            14: begin o.regwrite = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Runs one instruction; zmode 0/1 forces zero, 2 randomizes it each cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input bit rst_wr);
        int seq[$];
        seq = '{0, 1, 2, 3, 4};
        case (o)
            6'b100000: begin seq.push_back(5); seq.push_back(6); seq.push_back(7); end
            6'b101000: begin seq.push_back(5); seq.push_back(8); end
            6'b000000: begin seq.push_back(9); seq.push_back(10); end
            6'b000100: seq.push_back(11);
            6'b000010: seq.push_back(12);
`ifdef ADDI_EN
            6'b001000: begin seq.push_back(13); seq.push_back(14); end
`endif
            default: ;
        endcase
        foreach (seq[i]) begin
            @(posedge clk); #1;
            if (seq[i] < 4) begin
                op    = 6'($urandom_range(63));
                funct = 6'($urandom_range(63));
            end else begin
                op    = o;
                funct = f;
            end
            zero = (zmode == 2) ? 1'($urandom_range(1)) : (zmode == 1);
            exp_q.push_back(model_out(seq[i], funct, zero));
            if (rst_wr && seq[i] == 10) begin
                #5 reset = 1'b0;
                #1;
                checks++;
                if (state !== 4'd0 || regwrite !== 1'b0 || irwrite !== 4'd0 || memread !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: state=%0d regwrite=%b irwrite=%b memread=%b, required all 0",
                             state, regwrite, irwrite, memread);
                end
                @(posedge clk); #1;
                exp_q.push_back('0);
                #2 reset = 1'b1;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents a control word, compare it with the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {memread, memwrite, alusrca, alusrcb, iord, irwrite, memtoreg, regdst,
                 regwrite, pcen, pcsource, alucontrol, state};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_outputs: got=%h required=%h (required state %0d, got state %0d)",
                         g, e, e.state, g.state);
            end
            checks++;
            if ((memread && memwrite) || ($countones(irwrite) > 1)) begin
                errors++;
                $display("FAIL strobe_exclusive: memread=%b memwrite=%b irwrite=%b, required exclusive",
                         memread, memwrite, irwrite);
            end
        end
    end

    initial begin
        logic [5:0] ro, rf;
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            exp_q.push_back('0);
        end
        #2 reset = 1'b1;

        run_instr(6'b000000, 6'h20, 2, 1'b0);
        run_instr(6'b000000, 6'h20, 2, 1'b1);
        run_instr(6'b000000, 6'h20, 2, 1'b0);
        run_instr(6'b000100, 6'h00, 1, 1'b0);
        run_instr(6'b000100, 6'h00, 0, 1'b0);
        run_instr(6'b100000, 6'h00, 2, 1'b0);
        run_instr(6'b101000, 6'h00, 2, 1'b0);
        run_instr(6'b111111, 6'h20, 2, 1'b0);
        run_instr(6'b000000, 6'h00, 2, 1'b0);
        run_instr(6'b001000, 6'h00, 2, 1'b0);
        run_instr(6'b000010, 6'h00, 2, 1'b0);
        run_instr(6'b000000, 6'h2a, 2, 1'b0);

        repeat (80) begin
            case ($urandom_range(7))
                0: ro = 6'b100000;
                1: ro = 6'b101000;
                2: ro = 6'b000000;
                3: ro = 6'b000100;
                4: ro = 6'b000010;
                5: ro = 6'b001000;
                6: ro = 6'b111111;
                default: ro = 6'($urandom_range(63));
            endcase
            case ($urandom_range(6))
                0: rf = 6'h20;
                1: rf = 6'h22;
                2: rf = 6'h24;
                3: rf = 6'h25;
                4: rf = 6'h2a;
                5: rf = 6'h00;
                default: rf = 6'($urandom_range(63));
            endcase
            run_instr(ro, rf, 2, ($urandom_range(15) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
